// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one host packet, then drives router header/payload/parity
// framing with pkt_valid while honouring router busy backpressure.
module router_pkt_tx #(
    parameter int unsigned MAX_LEN    = 63,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] addr,
    input  logic [5:0] payload_len,
    input  logic       corrupt_parity,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_busy,
    output logic       done,
    output logic       cmd_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PARITY  = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [6:0] LEN_MAX   = 7'(MAX_LEN);

    logic [2:0]    r_state;
    logic [1:0]    r_addr;
    logic [5:0]    r_len;
    logic          r_corrupt;
    logic [7:0]    r_parity;
    logic [5:0]    r_cnt;
    logic [5:0]    r_idx;
    logic [GW-1:0] r_gap;
    logic          r_done;
    logic          r_cmd_err;
    logic [7:0]    r_buf [0:MAX_LEN-1];

    logic       w_cmd_bad;
    logic       w_accept;
    logic       w_xfer;
    logic [5:0] w_last;

    assign w_cmd_bad = (addr == 2'd3) || (payload_len == '0) || ({1'b0, payload_len} > LEN_MAX);
    assign w_last    = r_len - 6'd1;
    assign w_accept  = (r_state == S_LOAD) && pl_valid;
    // A byte moves to the router only when it is being presented and busy is low
    assign w_xfer    = !busy && ((r_state == S_HEADER) || (r_state == S_PAYLOAD) || (r_state == S_PARITY));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_corrupt <= 1'b0;
            r_parity  <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_gap     <= '0;
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cmd_bad) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_addr    <= addr;
                            r_len     <= payload_len;
                            r_corrupt <= corrupt_parity;
                            r_parity  <= {payload_len, addr};
                            r_cnt     <= '0;
                            r_state   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_parity <= r_parity ^ pl_data;
                        r_cnt    <= r_cnt + 6'd1;
                        if (r_cnt == w_last) begin
                            r_idx   <= '0;
                            r_state <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (w_xfer) r_state <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        if (r_idx == w_last) r_state <= S_PARITY;
                        else                 r_idx   <= r_idx + 6'd1;
                    end
                end
                S_PARITY: begin
                    if (w_xfer) begin
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) r_state <= S_IDLE;
                    else                   r_gap   <= r_gap + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) r_buf[r_cnt] <= pl_data;
    end

    always_comb begin
        pkt_valid = 1'b0;
        data_out  = '0;
        case (r_state)
            S_HEADER: begin
                pkt_valid = 1'b1;
                data_out  = {r_len, r_addr};
            end
            S_PAYLOAD: begin
                pkt_valid = 1'b1;
                data_out  = r_buf[r_idx];
            end
            S_PARITY: data_out = r_corrupt ? ~r_parity : r_parity;
            default: ;
        endcase
    end

    assign pl_ready = (r_state == S_LOAD);
    assign tx_busy  = (r_state != S_IDLE);
    assign done     = r_done;
    assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: randomized packet stimulus checked against a byte-stream and
// latency model of the router input protocol.
module tb_router_pkt_tx;

    localparam int unsigned MAX_LEN    = 63;
    localparam int unsigned GAP_CYCLES = 1;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [1:0] addr;
    logic [5:0] payload_len;
    logic       corrupt_parity;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_busy;
    logic       done;
    logic       cmd_err;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    logic [7:0]  g_pl [0:63];

    router_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clock(clock), .resetn(resetn), .start(start), .addr(addr),
        .payload_len(payload_len), .corrupt_parity(corrupt_parity),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
        .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out),
        .tx_busy(tx_busy), .done(done), .cmd_err(cmd_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sends one packet from g_pl and checks the whole router-side byte stream.
    // host_mode: 0 = pl_valid always high, 1 = toggled, 2 = random.
    // stall_idx >= 0 holds busy high for stall_len cycles while that stream byte is shown.
    // inject_idx >= 0 strobes a stray start while that stream byte is shown.
    task automatic send_packet(input logic [1:0] a, input int unsigned len, input logic cor,
                               input int unsigned host_mode, input int unsigned busy_pct,
                               input int stall_idx, input int unsigned stall_len,
                               input int inject_idx);
        logic [7:0]  exp_q[$];
        logic [7:0]  par;
        int unsigned sent, n_rx, cyc, extra, gap, stall_left;
        bit          finished, stalled, injected, acc;
        par = {len[5:0], a};
        exp_q.push_back(par);
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(g_pl[i]);
            par = par ^ g_pl[i];
        end
        exp_q.push_back(cor ? ~par : par);

        @(posedge clock); #1;
        start = 1'b1; addr = a; payload_len = len[5:0]; corrupt_parity = cor;
        pl_valid = 1'b0; busy = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        sent = 0; n_rx = 0; cyc = 1; extra = 0; gap = 0; stall_left = 0;
        finished = 0; stalled = 0; injected = 0;
        while (!finished && cyc < 3000) begin
            case (host_mode)
                0:       pl_valid = 1'b1;
                1:       pl_valid = cyc[0];
                default: pl_valid = 1'($urandom_range(0, 1));
            endcase
            pl_data = (pl_valid && sent < len) ? g_pl[sent] : 8'($urandom);
            if (stall_idx >= 0 && n_rx == unsigned'(stall_idx) && sent == len && !stalled) begin
                stalled = 1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                busy = 1'b1;
                stall_left--;
            end else begin
                busy = ($urandom_range(0, 99) < busy_pct);
            end
            start = 1'b0;
            if (inject_idx >= 0 && n_rx == unsigned'(inject_idx) && sent == len && !injected) begin
                injected = 1;
                start = 1'b1;
                addr = 2'($urandom_range(0, 3));
                payload_len = 6'($urandom_range(0, 63));
                corrupt_parity = 1'($urandom);
            end
            @(negedge clock);
            tests_run++;
            if (cmd_err !== 1'b0 || pl_ready !== (sent < len)) begin
                tests_failed++;
                $display("FAIL ctl cyc=%0d cmd_err=%b pl_ready=%b, expected cmd_err=0 pl_ready=%b",
                         cyc, cmd_err, pl_ready, (sent < len));
            end
            acc = pl_valid && (sent < len);
            if (sent < len) begin
                tests_run++;
                if (pkt_valid !== 1'b0 || tx_busy !== 1'b1 || done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL load cyc=%0d pkt_valid=%b tx_busy=%b done=%b, expected 0/1/0",
                             cyc, pkt_valid, tx_busy, done);
                end
                if (!pl_valid) extra++;
            end else if (n_rx <= len + 1) begin
                tests_run++;
                if (pkt_valid !== (n_rx <= len) || data_out !== exp_q[n_rx] ||
                    tx_busy !== 1'b1 || done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL byte%0d cyc=%0d data_out=%h pkt_valid=%b tx_busy=%b done=%b, expected %h/%b/1/0",
                             n_rx, cyc, data_out, pkt_valid, tx_busy, done, exp_q[n_rx], (n_rx <= len));
                end
                if (busy) extra++;
                else      n_rx++;
            end else begin
                gap++;
                if (gap == 1) begin
                    tests_run++;
                    if (done !== 1'b1 || pkt_valid !== 1'b0 || data_out !== 8'h00 || tx_busy !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL gap1 done=%b pkt_valid=%b data_out=%h tx_busy=%b, expected 1/0/00/1",
                                 done, pkt_valid, data_out, tx_busy);
                    end
                    tests_run++;
                    if (cyc != 2 * len + 3 + extra) begin
                        tests_failed++;
                        $display("FAIL latency done at cycle %0d, expected %0d", cyc, 2 * len + 3 + extra);
                    end
                end else if (gap <= GAP_CYCLES) begin
                    tests_run++;
                    if (done !== 1'b0 || tx_busy !== 1'b1 || pkt_valid !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL gap done=%b tx_busy=%b pkt_valid=%b, expected 0/1/0",
                                 done, tx_busy, pkt_valid);
                    end
                end else begin
                    tests_run++;
                    if (done !== 1'b0 || tx_busy !== 1'b0 || pkt_valid !== 1'b0 || data_out !== 8'h00) begin
                        tests_failed++;
                        $display("FAIL idle_after done=%b tx_busy=%b pkt_valid=%b data_out=%h, expected 0/0/0/00",
                                 done, tx_busy, pkt_valid, data_out);
                    end
                    finished = 1;
                end
            end
            if (acc) sent++;
            cyc++;
            if (!finished) begin
                @(posedge clock); #1;
            end
        end
        tests_run++;
        if (!finished) begin
            tests_failed++;
            $display("FAIL timeout packet not finished, got %0d stream bytes, expected %0d", n_rx, len + 2);
        end
        @(posedge clock); #1;
        pl_valid = 1'b0; busy = 1'b0; start = 1'b0;
    endtask

    task automatic fill_random(input int unsigned len);
        for (int i = 0; i < int'(len); i++) g_pl[i] = 8'($urandom);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        tests_run++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00 || pl_ready !== 1'b0 ||
            tx_busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset pv=%b do=%h rdy=%b txb=%b done=%b err=%b, expected all zero",
                     pkt_valid, data_out, pl_ready, tx_busy, done, cmd_err);
        end
        resetn = 1'b1;
    endtask

    task automatic test_good_packet;
        g_pl[0] = 8'hA5; g_pl[1] = 8'h3C; g_pl[2] = 8'hFF;
        send_packet(2'd2, 3, 1'b0, 0, 0, -1, 0, -1);
    endtask

    task automatic test_bad_parity;
        g_pl[0] = 8'hA5; g_pl[1] = 8'h3C; g_pl[2] = 8'hFF;
        send_packet(2'd2, 3, 1'b1, 0, 0, -1, 0, -1);
    endtask

    task automatic test_router_stall;
        g_pl[0] = 8'hA5; g_pl[1] = 8'h3C; g_pl[2] = 8'hFF;
        send_packet(2'd2, 3, 1'b0, 0, 0, 2, 3, -1);
    endtask

    task automatic test_host_stall_max;
        fill_random(63);
        send_packet(2'd1, 63, 1'b0, 1, 0, -1, 0, -1);
    endtask

    task automatic test_min_len;
        fill_random(1);
        send_packet(2'd0, 1, 1'b0, 0, 0, -1, 0, -1);
    endtask

    task automatic test_cmd_err;
        logic [1:0] bad_addr [0:1];
        logic [5:0] bad_len  [0:1];
        bad_addr[0] = 2'd3; bad_len[0] = 6'd5;
        bad_addr[1] = 2'd0; bad_len[1] = 6'd0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            start = 1'b1; addr = bad_addr[k]; payload_len = bad_len[k]; corrupt_parity = 1'b0;
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock);
            tests_run++;
            if (cmd_err !== 1'b1 || tx_busy !== 1'b0 || pkt_valid !== 1'b0 || pl_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL cmd_err%0d err=%b txb=%b pv=%b rdy=%b, expected 1/0/0/0",
                         k, cmd_err, tx_busy, pkt_valid, pl_ready);
            end
            @(negedge clock);
            tests_run++;
            if (cmd_err !== 1'b0 || tx_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL cmd_err%0d_pulse err=%b txb=%b, expected 0/0", k, cmd_err, tx_busy);
            end
        end
    endtask

    task automatic test_ignored_start;
        fill_random(6);
        send_packet(2'd1, 6, 1'b0, 0, 0, -1, 0, 3);
    endtask

    task automatic test_reset_mid;
        bit          seen;
        int unsigned sent;
        g_pl[0] = 8'h11; g_pl[1] = 8'h22; g_pl[2] = 8'h33; g_pl[3] = 8'h44; g_pl[4] = 8'h55;
        @(posedge clock); #1;
        start = 1'b1; addr = 2'd0; payload_len = 6'd5; corrupt_parity = 1'b0;
        @(posedge clock); #1;
        start = 1'b0; busy = 1'b0;
        seen = 0; sent = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            pl_valid = (sent < 5);
            pl_data = (sent < 5) ? g_pl[sent] : 8'h00;
            @(negedge clock);
            if (pl_valid && pl_ready) sent++;
            if (pkt_valid === 1'b1 && data_out === 8'h22) seen = 1;
            @(posedge clock); #1;
        end
        pl_valid = 1'b0;
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL reset_mid_wait second payload byte not seen, expected 22");
        end
        #1 resetn = 1'b0;
        #1;
        tests_run++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00 || tx_busy !== 1'b0 || pl_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid pv=%b do=%h txb=%b rdy=%b, expected 0/00/0/0",
                     pkt_valid, data_out, tx_busy, pl_ready);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            tests_run++;
            if (done !== 1'b0 || pkt_valid !== 1'b0 || tx_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_after done=%b pv=%b txb=%b, expected 0/0/0", done, pkt_valid, tx_busy);
            end
        end
        fill_random(4);
        send_packet(2'd2, 4, 1'b0, 0, 0, -1, 0, -1);
    endtask

    task automatic test_random;
        int unsigned len;
        for (int n = 0; n < 8; n++) begin
            len = (n == 7) ? 63 : $urandom_range(1, 20);
            fill_random(len);
            send_packet(2'($urandom_range(0, 2)), len, 1'($urandom), 2, 30, -1, 0,
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len)) : -1);
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; addr = '0; payload_len = '0; corrupt_parity = 1'b0;
        pl_valid = 1'b0; pl_data = '0; busy = 1'b0;
        test_reset;
        test_good_packet;
        test_bad_parity;
        test_router_stall;
        test_host_stall_max;
        test_min_len;
        test_cmd_err;
        test_ignored_start;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
